// File: rtl/led_pkg.sv
// Shared constants and types for the WS2812 frame scheduler and its serializer.
package led_pkg;

  localparam logic [7:0] ADDR_CTRL  = 8'hC2;
  localparam logic [7:0] ADDR_INDEX = 8'hC3;
  localparam logic [7:0] ADDR_G     = 8'hC4;
  localparam logic [7:0] ADDR_R     = 8'hC5;
  localparam logic [7:0] ADDR_B     = 8'hC6;
  localparam logic [7:0] ADDR_LEN   = 8'hC7;

  // Cycle counts at 50 MHz: 60 us latch gap, 20 ms refresh, 0.4/0.8 us high times.
  localparam int unsigned LED_RESET_CYC   = 3000;
  localparam int unsigned LED_REFRESH_CYC = 1_000_000;
  localparam int unsigned T0H_CYC         = 20;
  localparam int unsigned T1H_CYC         = 40;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    DRAIN,
    GAP
  } state_t;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } pixel_t;

endpackage

// File: rtl/led_frame_sched_if.sv
// Pixel stream between the frame scheduler (master) and the bit serializer (slave).
interface led_frame_sched_if;
  import led_pkg::*;

  logic   pix_valid;
  pixel_t pix_data;
  logic   pix_last;
  logic   pix_ready;
  logic   ser_busy;

  modport master (
    output pix_valid, pix_data, pix_last,
    input  pix_ready, ser_busy
  );

  modport slave (
    input  pix_valid, pix_data, pix_last,
    output pix_ready, ser_busy
  );

endinterface

// File: rtl/led_cycle_timer.sv
// Free-running 0..CYC-1 counter with a terminal-count pulse; load or !en holds it at 0.
module led_cycle_timer #(
  parameter int unsigned CYC = 3000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = (CYC > 1) ? $clog2(CYC) : 1;
  localparam logic [W-1:0] LAST = W'(CYC - 1);

  logic [W-1:0] cnt;

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || load || !en) begin
      cnt <= '0;
    end else begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tc = en && !load && (cnt == LAST);

endmodule

// File: rtl/led_frame_sched.sv
// WS2812 frame scheduler: SFR-written back buffer, snapshot to front buffer, pixel
// streaming over valid/ready, drain, latch gap, and an optional auto-refresh timer.
module led_frame_sched
  import led_pkg::*;
#(
  parameter int unsigned NUM_LEDS    = 8,
  parameter int unsigned RESET_CYC   = LED_RESET_CYC,
  parameter int unsigned REFRESH_CYC = LED_REFRESH_CYC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               sfr_addr,
  input  logic [7:0]               controller_data_in,
  input  logic                     sfr_wr,
  led_frame_sched_if.master        pix,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int unsigned IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int unsigned LW = $clog2(NUM_LEDS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LEDS - 1);
  localparam logic [7:0]    MAX_LEN  = 8'(NUM_LEDS);
  localparam logic [LW-1:0] FULL_LEN = LW'(NUM_LEDS);

  state_t         state, state_next;
  pixel_t         back_buf  [NUM_LEDS];
  pixel_t         front_buf [NUM_LEDS];
  logic [7:0]     stage_g, stage_r;
  logic [IW-1:0]  wr_idx, rd_idx;
  logic [LW-1:0]  len;
  logic           auto_en, start_q, pending;
  logic           gap_tc, auto_tc;
  logic           ctrl_wr, is_last, accept;

  assign ctrl_wr = sfr_wr && (sfr_addr == ADDR_CTRL);
  assign is_last = (LW'(rd_idx) + LW'(1)) == len;
  assign accept  = (state == SEND) && pix.pix_ready;

  led_cycle_timer #(.CYC(RESET_CYC)) u_gap_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state != GAP),
    .en    (state == GAP),
    .tc    (gap_tc)
  );

  led_cycle_timer #(.CYC(REFRESH_CYC)) u_refresh_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (!auto_en),
    .en    (auto_en),
    .tc    (auto_tc)
  );

  // SFR decode and back buffer; the back buffer stays writable in every state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_g <= '0;
      stage_r <= '0;
      wr_idx  <= '0;
      len     <= FULL_LEN;
      auto_en <= 1'b0;
      start_q <= 1'b0;
      // NOTE: pixel memories get an explicit reset because black-after-reset is visible behaviour.
      for (int i = 0; i < NUM_LEDS; i++) back_buf[i] <= '0;
    end else begin
      start_q <= (ctrl_wr && controller_data_in[0]) || auto_tc;
      if (sfr_wr) begin
        case (sfr_addr)
          ADDR_CTRL:  auto_en <= controller_data_in[1];
          ADDR_INDEX: wr_idx  <= IW'(controller_data_in % NUM_LEDS);
          ADDR_G:     stage_g <= controller_data_in;
          ADDR_R:     stage_r <= controller_data_in;
          ADDR_B: begin
            back_buf[wr_idx] <= '{g: stage_g, r: stage_r, b: controller_data_in};
            wr_idx           <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
          end
          ADDR_LEN: begin
            if (controller_data_in == 8'd0 || controller_data_in > MAX_LEN) len <= FULL_LEN;
            else                                                              len <= LW'(controller_data_in);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: next state gets a default before the case so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_q || pending) state_next = LOAD;
      LOAD:    state_next = SEND;
      SEND:    if (accept && is_last) state_next = DRAIN;
      DRAIN:   if (!pix.ser_busy) state_next = GAP;
      GAP:     if (gap_tc) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Front buffer snapshot, read pointer, one-deep start pending and the done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_idx     <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) front_buf[i] <= '0;
    end else begin
      frame_done <= (state == GAP) && gap_tc;
      if (state == IDLE) pending <= 1'b0;
      else if (start_q)  pending <= 1'b1;
      if (state == LOAD) begin
        front_buf <= back_buf;
        rd_idx    <= '0;
      end else if (accept && !is_last) begin
        rd_idx <= rd_idx + 1'b1;
      end
    end
  end

  assign pix.pix_valid = (state == SEND);
  assign pix.pix_data  = (state == SEND) ? front_buf[rd_idx] : '0;
  assign pix.pix_last  = (state == SEND) && is_last;
  assign busy          = (state != IDLE);

endmodule

// File: doc/led_frame_sched.md
# led_frame_sched

Frame scheduler for the WS2812 LED chain, sitting between the 8051 SFR bus and the bit-level serializer that drives `din`. It holds a double-buffered per-LED GRB pixel memory written by firmware and starts frames on command or on an auto-refresh timer. It streams one 24-bit pixel at a time to the serializer over a valid/ready handshake, then enforces the ≥60 µs latch gap. It replaces the fixed-colour/one-second-cycle sequencing with firmware-controlled per-LED colour.

## Interface
Parameters:
- NUM_LEDS, 8: pixel buffer depth, 1..16
- RESET_CYC, 3000: latch-gap length in clk cycles (60 µs at 50 MHz)
- REFRESH_CYC, 1000000: auto-refresh period in clk cycles (20 ms)

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  synchronous active-low reset
- sfr_addr  in  8  SFR address
- controller_data_in  in  8  SFR write data
- sfr_wr  in  1  SFR write strobe, one cycle per write
- pix_valid  out  1  pixel offered to serializer
- pix_data  out  24  pixel, {G,R,B}, MSB sent first
- pix_last  out  1  pixel is last of frame, qualified by pix_valid
- pix_ready  in  1  serializer accepts pixel
- ser_busy  in  1  serializer still shifting bits
- busy  out  1  state ≠ IDLE
- frame_done  out  1  one-cycle pulse at end of latch gap

## Operation
- SFR map, decoded only when sfr_wr=1:
  - 0xC2 CTRL: bit0=1 requests a frame (self-clearing); bit1 = auto-refresh enable (stored)
  - 0xC3 INDEX: write pointer; values ≥ NUM_LEDS wrap modulo NUM_LEDS
  - 0xC4 G and 0xC5 R: staging bytes
  - 0xC6 B: writes {G,R,B} into back[INDEX], then INDEX ← (INDEX+1) mod NUM_LEDS
  - 0xC7 LEN: active LED count; 0 or > NUM_LEDS is stored as NUM_LEDS
- Back buffer is always writable. Front buffer is loaded from the back buffer in one cycle in LOAD, so writes during a frame affect only the next frame.
- FSM:
  - IDLE: on a start request → LOAD
  - LOAD: front ← back, idx ← 0 → SEND
  - SEND: pix_valid=1, pix_data=front[idx], pix_last=(idx==LEN-1). On valid&ready, idx+1; if last → DRAIN.
  - DRAIN: wait ser_busy=0 → GAP
  - GAP: count RESET_CYC cycles → IDLE with frame_done pulse
- Start sources are a CTRL bit0 write and auto-timer expiry. A start arriving outside IDLE sets a one-deep pending flag. Further starts while pending are dropped. Pending is consumed on return to IDLE.
- Auto timer: counts 0..REFRESH_CYC-1 while bit1=1 and raises a start at the terminal count. It clears to 0 when bit1=0.

## Timing
- Reset values: pix_valid=0, pix_data=0, pix_last=0, busy=0, frame_done=0. State IDLE, both buffers 0 (black), staging 0, INDEX=0, LEN=NUM_LEDS, auto off, pending 0, timers 0.
- CTRL start written at edge N: LOAD at N+1, pix_valid=1 at N+2.
- pix_data/pix_last are stable while pix_valid=1 and ready=0. Next pixel is presented the cycle after acceptance; back-to-back acceptance is allowed.
- GAP entered the cycle after ser_busy is seen 0. frame_done is high exactly RESET_CYC cycles after GAP entry, in the cycle busy falls.
- Start coincident with GAP→IDLE sets pending; LOAD follows one cycle after IDLE, so frames are separated by ≥ RESET_CYC+1 idle cycles.
- A B-write in the LOAD cycle goes to the back buffer after the snapshot, so it appears in the next frame only.
- INDEX write and B-write in different cycles are processed in order. INDEX wraps from NUM_LEDS-1 to 0.
- rst_n low during any state: all registers take reset values at that edge, pix_valid drops, and no frame_done is emitted.

## Structure
- Package led_pkg holds:
  - SFR address constants 0xC2–0xC7
  - the state enum (IDLE, LOAD, SEND, DRAIN, GAP)
  - the 24-bit GRB pixel type
  - the 50 MHz-based RESET_CYC and T0H/T1H constants shared with the serializer
- One natural sub-module, led_cycle_timer (load/enable/terminal-count pulse), instantiated twice: latch gap and auto-refresh.

## Test plan
- Reset, then write LEN=3, INDEX=0, G/R/B = 0x10/0x20/0x30, 0x40/0x50/0x60, 0x70/0x80/0x90, then CTRL=0x01 → pixels 0x102030, 0x405060, 0x708090 in order, pix_last only on the third, frame_done 3000 cycles after ser_busy falls.
- Hold pix_ready=0 for 50 cycles mid-frame → pix_data/pix_last held constant, no pixel skipped or repeated.
- During SEND, write new colour to INDEX 0 → current frame sends the old value; next frame sends the new value.
- Two CTRL starts during GAP → exactly one extra frame follows, LOAD starts one cycle after IDLE.
- CTRL=0x02 with REFRESH_CYC=1000 (test override) → frames start every 1000 cycles or at the next IDLE, whichever is later. Then write CTRL=0x00 → no further starts.
- Assert rst_n=0 for one cycle mid-SEND → next cycle pix_valid=0, busy=0, LEN=NUM_LEDS, buffers read back black on the next frame.
